// File: rtl/matvec_requant.sv
// Requantisation stage after the matvec wrapper: captures one accumulator vector, adds bias,
// rounds, shifts and saturates per channel, then streams LANES channels per beat. Optional ReLU: MATVEC_REQUANT_RELU_EN.
module matvec_requant #(
  parameter int OUT_C = 32,
  parameter int LANES = 4,
  parameter int ACC_W = 16,
  parameter int OUT_W = 8,
  parameter int SHIFT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [OUT_C*ACC_W-1:0]   in_acc_pack,
  input  logic [OUT_C*ACC_W-1:0]   bias_pack,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*OUT_W-1:0]   out_data,
  output logic                     out_last,
  output logic                     overflow,
  output logic [1:0]               dbg_state
);

  localparam int NG    = OUT_C / LANES;
  localparam int CNT_W = (NG > 1) ? $clog2(NG) : 1;
  localparam int RW    = ACC_W + 2;
  // Half-LSB rounding constant; collapses to zero when SHIFT is 0.
  localparam logic signed [RW-1:0] RND     = RW'((64'd1 << SHIFT) >> 1);
  localparam logic signed [RW-1:0] SAT_MAX = RW'((64'd1 << (OUT_W - 1)) - 64'd1);
  localparam logic signed [RW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEND  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                   r_state;
  logic [OUT_C*ACC_W-1:0]   r_vec;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_out_valid;
  logic                     r_out_last;
  logic [LANES*OUT_W-1:0]   r_out_data;
  logic                     r_overflow;
  logic [LANES*OUT_W-1:0]   w_beat;
  logic                     w_last_grp;

  function automatic logic [OUT_W-1:0] requant(input logic [ACC_W-1:0] acc,
                                               input logic [ACC_W-1:0] bias);
    logic signed [RW-1:0] s;
    logic signed [RW-1:0] r;
    s = $signed({{2{acc[ACC_W-1]}}, acc}) + $signed({{2{bias[ACC_W-1]}}, bias});
    r = (s + RND) >>> SHIFT;
`ifdef MATVEC_REQUANT_RELU_EN
    if (r < 0) r = '0;
`endif
    if (r > SAT_MAX) r = SAT_MAX;
    else if (r < SAT_MIN) r = SAT_MIN;
    return r[OUT_W-1:0];
  endfunction

  always_comb begin
    w_beat = '0;
    for (int l = 0; l < LANES; l++) begin
      w_beat[l*OUT_W +: OUT_W] =
        requant(r_vec[(int'(r_cnt) * LANES + l) * ACC_W +: ACC_W],
                bias_pack[(int'(r_cnt) * LANES + l) * ACC_W +: ACC_W]);
    end
  end

  assign w_last_grp = (r_cnt == CNT_W'(NG - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_vec       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_overflow  <= 1'b0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      // Any vector offered while not IDLE is lost; the flag stays until reset.
      if (in_valid && r_state != S_IDLE) r_overflow <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_vec   <= in_acc_pack;
            r_cnt   <= '0;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          if (!r_out_valid || out_ready) begin
            r_out_data  <= w_beat;
            r_out_valid <= 1'b1;
            r_out_last  <= w_last_grp;
            r_cnt       <= r_cnt + 1'b1;
            if (w_last_grp) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Handshake: a beat moves on out_valid && out_ready; data/last hold while stalled.
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign overflow  = r_overflow;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_matvec_requant.sv
// Randomised bench for matvec_requant: SHIFT=4 and SHIFT=0 instances share stimulus and
// are scored against an integer-arithmetic reference model.
module tb_matvec_requant;

  localparam int OUT_C = 32;
  localparam int LANES = 4;
  localparam int ACC_W = 16;
  localparam int OUT_W = 8;
  localparam int NG    = OUT_C / LANES;
  localparam int BW    = LANES * OUT_W;
  localparam int EW    = 2 * BW + 1;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   flush;
  logic                   in_valid;
  logic [OUT_C*ACC_W-1:0] in_acc_pack;
  logic [OUT_C*ACC_W-1:0] bias_pack;
  logic                   out_ready = 1'b1;
  logic                   in_ready_a, out_valid_a, out_last_a, overflow_a;
  logic                   in_ready_b, out_valid_b, out_last_b, overflow_b;
  logic [BW-1:0]          out_data_a, out_data_b;
  logic [1:0]             dbg_state_a, dbg_state_b;

  logic [EW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            n_pops   = 0;
  int            vacc[OUT_C];
  int            vbias[OUT_C];
  logic          rand_ready  = 1'b0;
  logic          ready_fixed = 1'b1;

  // clock / reset
  always #5 clk = ~clk;

  matvec_requant #(.OUT_C(OUT_C), .LANES(LANES), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(4)) u_dut_s4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .in_acc_pack(in_acc_pack), .bias_pack(bias_pack), .in_ready(in_ready_a),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .out_last(out_last_a), .overflow(overflow_a), .dbg_state(dbg_state_a)
  );

  matvec_requant #(.OUT_C(OUT_C), .LANES(LANES), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(0)) u_dut_s0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .in_acc_pack(in_acc_pack), .bias_pack(bias_pack), .in_ready(in_ready_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .out_last(out_last_b), .overflow(overflow_b), .dbg_state(dbg_state_b)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: floor((acc+bias+d/2)/d) with d=2^shift, optional ReLU, then clamp.
  function automatic int requant_ref(input int acc, input int bias, input int shift);
    longint d, num, q;
    d   = longint'(1) << shift;
    num = longint'(acc) + longint'(bias) + d / 2;
    q   = num / d;
    if ((num % d) != 0 && num < 0) q = q - 1;
`ifdef MATVEC_REQUANT_RELU_EN
    if (q < 0) q = 0;
`endif
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return int'(q);
  endfunction

  task automatic push_expected();
    logic [BW-1:0] d4, d0;
    for (int g = 0; g < NG; g++) begin
      for (int l = 0; l < LANES; l++) begin
        d4[l*OUT_W +: OUT_W] = OUT_W'(requant_ref(vacc[g*LANES+l], vbias[g*LANES+l], 4));
        d0[l*OUT_W +: OUT_W] = OUT_W'(requant_ref(vacc[g*LANES+l], vbias[g*LANES+l], 0));
      end
      exp_q.push_back({(g == NG - 1), d4, d0});
    end
  endtask

  task automatic fill_random(input bit new_bias);
    logic signed [15:0] t;
    for (int c = 0; c < OUT_C; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        t = 16'($urandom());
        vacc[c] = int'(t);
      end else begin
        vacc[c] = int'($urandom_range(0, 6000)) - 3000;
      end
      if (new_bias) vbias[c] = int'($urandom_range(0, 2000)) - 1000;
    end
  endtask

  // driver: one-cycle in_valid pulse; accept says whether the vector should be taken
  task automatic send_vec(input bit accept);
    @(posedge clk); #1;
    for (int c = 0; c < OUT_C; c++) begin
      in_acc_pack[c*ACC_W +: ACC_W] = ACC_W'(vacc[c]);
      bias_pack[c*ACC_W +: ACC_W]   = ACC_W'(vbias[c]);
    end
    in_valid = 1'b1;
    if (accept) push_expected();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("drain_remaining", exp_q.size(), 0);
    @(negedge clk);
    check("idle_in_ready", in_ready_a, 1'b1);
  endtask

  always @(posedge clk) begin
    #2;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
  end

  // scoreboard monitor
  logic [EW-1:0] mon_e;
  logic [BW-1:0] held_data;
  bit            stalled = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_hold_valid", out_valid_a, 1'b1);
        check("stall_hold_data", out_data_a, held_data);
      end
      if (out_valid_a && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", out_valid_a, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          check("data_s4", out_data_a, mon_e[2*BW-1:BW]);
          check("data_s0", out_data_b, mon_e[BW-1:0]);
          check("last_s4", out_last_a, mon_e[EW-1]);
          check("last_s0", out_last_b, mon_e[EW-1]);
          n_pops++;
        end
      end
      stalled   = out_valid_a && !out_ready && !flush;
      held_data = out_data_a;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int base, t;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_acc_pack = '0; bias_pack = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid_a, 1'b0);
    check("rst_out_last", out_last_a, 1'b0);
    check("rst_out_data", out_data_a, '0);
    check("rst_in_ready", in_ready_a, 1'b1);
    check("rst_overflow", overflow_a, 1'b0);
    check("rst_state_s4", dbg_state_a, 2'd0);
    check("rst_state_s0", dbg_state_b, 2'd0);
    rst = 1'b0;

    // basic vector with latency and beat content checks
    for (int c = 0; c < OUT_C; c++) begin
      vacc[c] = 16 * c;
      vbias[c] = 0;
    end
    vacc[0] = 100; vbias[0] = 4;
    send_vec(1'b1);
    @(negedge clk);
    check("latency_t1_valid", out_valid_a, 1'b0);
    @(negedge clk);
    check("latency_t2_valid", out_valid_a, 1'b1);
    check("basic_beat0_lane0", out_data_a[7:0], 8'd7);
    @(negedge clk);
    check("basic_beat1", out_data_a, 32'h07060504);
    wait_drain();

    // rounding, negatives and saturation corners
    fill_random(1'b1);
    vacc[0] = -100;   vbias[0] = 8;
    vacc[1] = 24;     vbias[1] = 0;
    vacc[2] = -24;    vbias[2] = 0;
    vacc[3] = 10000;  vbias[3] = 0;
    vacc[4] = -10000; vbias[4] = 0;
    vacc[5] = 5;      vbias[5] = -3;
    send_vec(1'b1);
    @(negedge clk);
    @(negedge clk);
`ifdef MATVEC_REQUANT_RELU_EN
    check("round_beat0_s4", out_data_a, 32'h7F000200);
`else
    check("round_beat0_s4", out_data_a, 32'h7FFF02FA);
`endif
    @(negedge clk);
`ifdef MATVEC_REQUANT_RELU_EN
    check("sat_neg_s4", out_data_a[7:0], 8'h00);
`else
    check("sat_neg_s4", out_data_a[7:0], 8'h80);
`endif
    check("shift0_ch5", out_data_b[15:8], 8'h02);
    wait_drain();

    // random back-pressure
    rand_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      fill_random(1'b1);
      send_vec(1'b1);
      wait_drain();
    end
    rand_ready = 1'b0;
    ready_fixed = 1'b1;

    // flush while beat 3 is stalled, with a coincident in_valid
    fill_random(1'b1);
    base = n_pops;
    send_vec(1'b1);
    t = 0;
    while (n_pops < base + 3 && t < 100) begin
      @(posedge clk);
      t++;
    end
    check("flush_reach_beat3", n_pops - base, 3);
    #1;
    ready_fixed = 1'b0;
    flush = 1'b1;
    in_valid = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    ready_fixed = 1'b1;
    @(negedge clk);
    check("flush_out_valid", out_valid_a, 1'b0);
    check("flush_out_last", out_last_a, 1'b0);
    check("flush_in_ready", in_ready_a, 1'b1);
    check("flush_no_overflow", overflow_a, 1'b0);
    fill_random(1'b1);
    send_vec(1'b1);
    wait_drain();

    // overflow: second vector while sending is dropped
    fill_random(1'b1);
    send_vec(1'b1);
    fill_random(1'b0);
    send_vec(1'b0);
    @(negedge clk);
    check("overflow_set_s4", overflow_a, 1'b1);
    check("overflow_set_s0", overflow_b, 1'b1);
    wait_drain();
    repeat (3) begin
      @(negedge clk);
      check("overflow_no_extra", out_valid_a, 1'b0);
    end
    fill_random(1'b1);
    send_vec(1'b1);
    wait_drain();
    check("overflow_sticky", overflow_a, 1'b1);

    // asynchronous reset mid-vector
    fill_random(1'b1);
    send_vec(1'b1);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid_a, 1'b0);
    check("arst_out_last", out_last_a, 1'b0);
    check("arst_out_data", out_data_a, '0);
    check("arst_in_ready_s0", in_ready_b, 1'b1);
    check("arst_overflow", overflow_a, 1'b0);
    check("arst_state", dbg_state_a, 2'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_idle", out_valid_a, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/matvec_requant.md
Name: matvec_requant

Overview:
- Stage directly downstream of the matvec wrapper in the graph-conv datapath.
- Captures one full accumulator vector (OUT_C × ACC_W) on the matvec valid pulse.
- Per channel: adds bias, rounds, arithmetic-shifts, and saturates to feature width.
- Streams the results out LANES channels per beat over a valid/ready handshake to the next feature buffer.

Parameters:
- OUT_C, 32, number of output channels; must be a multiple of LANES.
- LANES, 4, channels emitted per output beat.
- ACC_W, aegnn B_WIDTH, signed accumulator and bias width.
- OUT_W, aegnn F_WIDTH, signed output feature width.
- SHIFT, 4, requantisation right shift, range 0..ACC_W-1.

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous active-high reset.
- flush, input, 1, synchronous abort; returns the block to IDLE.
- in_valid, input, 1, single-cycle pulse; accumulator vector is valid.
- in_acc_pack, input, OUT_C*ACC_W, signed accumulators; channel c at bits [c*ACC_W +: ACC_W].
- bias_pack, input, OUT_C*ACC_W, signed per-channel bias; static while busy.
- in_ready, output, 1, high only in IDLE.
- out_valid, output, 1, beat valid.
- out_ready, input, 1, downstream accepts the beat.
- out_data, output, LANES*OUT_W, beat g lane l = channel g*LANES+l.
- out_last, output, 1, high on the final beat of a vector.
- overflow, output, 1, sticky flag: a vector was dropped because the block was busy.

Behaviour:
- Reset: asynchronous on rst high. State=IDLE; in_ready=1; out_valid=0; out_data=0; out_last=0; overflow=0; beat counter=0; capture register=0.
- States:
  - IDLE: in_valid captures in_acc_pack into the vector register, counter=0, go to SEND.
  - SEND: while the output register is free (!out_valid || out_ready), compute group counter, load out_data, set out_valid, set out_last = (counter==OUT_C/LANES-1), increment counter. After the last group is loaded, go to DRAIN.
  - DRAIN: when out_valid && out_ready, clear out_valid and out_last, go to IDLE.
- Latency: in_valid at cycle t gives first out_valid at t+2 when unstalled. After that, one beat per cycle; a vector takes OUT_C/LANES beats.
- Handshake:
  - A beat transfers on out_valid && out_ready.
  - out_data and out_last stay stable while out_valid && !out_ready.
  - out_valid never drops without a transfer, except on flush or reset.
- Arithmetic, per channel:
  - s = sext(acc) + sext(bias), width ACC_W+1.
  - If SHIFT>0: r = (s + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift, width ACC_W+2, round-half-up. If SHIFT=0: r = s.
  - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Boundaries:
  - in_valid while not IDLE: vector dropped, overflow set; overflow clears only on rst.
  - in_valid in the same cycle that DRAIN returns to IDLE: dropped; in_ready is registered state, not a combinational look-ahead.
  - flush: has priority over everything. Next cycle state=IDLE, out_valid=0, out_last=0, counter=0. An in_valid in the same cycle is ignored and overflow is not set. overflow is unaffected.
  - out_ready held low forever: block holds the current beat indefinitely; no data loss.
  - Reset mid-vector: all state discarded immediately; no partial beat is emitted afterwards.

Optional Feature:
- Macro: MATVEC_REQUANT_RELU_EN.
- Defined: ReLU is applied after rounding and before saturation; negative r becomes 0. Output range is [0, 2^(OUT_W-1)-1].
- Undefined: signed saturation only; negative outputs pass through.

Test Plan:
- Basic (OUT_W=8, SHIFT=4, LANES=4, out_ready=1): channel 0 acc=100, bias=4 → 7. Other channels acc=16*c, bias=0 → c. Expect 8 beats on cycles t+2..t+9; out_last only on beat 7; beat 1 = {7,6,5,4} in lanes {3,2,1,0}.
- Rounding/negatives: acc=-100, bias=8 → -6 without RELU_EN, 0 with RELU_EN. acc=24 → 2 (1.5 rounds up). acc=-24 → -1.
- Saturation: acc=10000 → 127. acc=-10000 → -128 without RELU_EN, 0 with it. Repeat at SHIFT=0: acc=5, bias=-3 → 2.
- Back-pressure: toggle out_ready on a random pattern. Expect all 8 beats in order, data stable during stalls, exactly one out_last.
- Overflow: second in_valid while in SEND → overflow=1, no extra beats, first vector intact. A third vector sent after return to IDLE is processed normally; overflow stays 1.
- Flush/reset: flush asserted mid-beat 3 with out_ready=0 → next cycle out_valid=0, in_ready=1; a new vector then starts at beat 0. rst asserted mid-vector → all outputs at reset values in the same cycle.
